mode_counter: RTL and testbench
===============================

Name: mode_counter

Overview:
Parametrised successor to the team's 8-bit loadable up counter.
- Adds width, up/down direction, a programmable upper bound, wrap or saturate mode, a terminal-count pulse and a sticky overflow flag.
- Used as the general-purpose edge/window counter in the PUF response path, for example counting ring-oscillator edges or timing measurement windows.
- Lower bound is the start value supplied on init_val, as in the existing counter.

Parameters:
- WIDTH, 8, counter width in bits (legal range 2..32).
- RESET_TC, 0, reset value of tc and ovf (kept as a parameter for bench override only; synthesis leaves it at 0).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- enable  input  1  count-advance qualifier.
- dir  input  1  0 = count up, 1 = count down.
- mode  input  1  0 = wrap, 1 = saturate.
- init_val  input  WIDTH  start value and lower bound.
- limit_val  input  WIDTH  upper bound.
- load  input  1  synchronous load strobe.
- load_val  input  WIDTH  value written on load.
- clr_ovf  input  1  clears the sticky overflow flag.
- count  output  WIDTH  registered count.
- tc  output  1  registered one-cycle terminal-count pulse.
- ovf  output  1  registered sticky overflow/saturation flag.

Behaviour:
- Reset and clocking: one clock (clk); reset is synchronous and active-high.
- Reset values:
  - count <= init_val, sampled in the reset cycle.
  - tc <= 0, ovf <= 0.
- Priority per cycle: reset > load > enable. With none of these asserted, count holds and tc = 0.
- load: count <= load_val. tc = 0 that cycle and ovf is unchanged. No range check is made.
- enable, dir = 0 (up):
  - count != limit_val: count <= count + 1, modulo 2^WIDTH.
  - count == limit_val, wrap mode: count <= init_val, tc <= 1, ovf <= 1.
  - count == limit_val, saturate mode: count holds, tc <= 1, ovf <= 1. tc repeats every enabled cycle while held.
- enable, dir = 1 (down):
  - count != init_val: count <= count - 1, modulo 2^WIDTH.
  - count == init_val, wrap mode: count <= limit_val, tc <= 1, ovf <= 1.
  - count == init_val, saturate mode: count holds, tc <= 1, ovf <= 1.
- Latency: a boundary event sets count, tc and ovf on the same edge. tc is high for exactly the following cycle unless another event occurs.
- Bound checks use equality only. If count is outside [init_val, limit_val] (after a load, or when init_val > limit_val), the counter rolls modulo 2^WIDTH until it reaches a bound.
- init_val == limit_val: every enabled cycle is a boundary event.
- clr_ovf:
  - Clears ovf on the next edge.
  - clr_ovf together with a new boundary event in the same cycle leaves ovf = 1 (set wins).
  - clr_ovf with load or hold clears ovf.
- dir and mode are sampled every cycle. A change takes effect on the next enabled edge with no pipeline.
- Reset mid-count discards the count, tc and ovf, even during saturation hold.
- init_val and limit_val changing mid-count: the new bounds apply from that cycle.

Optional Feature:
- Macro: MODE_COUNTER_CAPTURE_EN.
- Defined:
  - Adds inputs capture (1) and outputs cap_val (WIDTH) and cap_valid (1).
  - On capture, cap_val <= count as it was before that edge's update, and cap_valid <= 1.
  - cap_valid clears on the next capture-free cycle, so it is a one-cycle pulse.
  - Reset: cap_val = 0, cap_valid = 0.
  - capture with reset: reset wins.
- Not defined: the ports are absent and there is no capture register logic.

Decomposition:
- Package mode_counter_pkg holds:
  - constants MODE_WRAP = 1'b0, MODE_SAT = 1'b1, DIR_UP = 1'b0, DIR_DOWN = 1'b1.
  - the typedef for the mode/dir bits.
- Sub-module mode_counter_next: purely combinational next-count and event calculation (count, dir, mode, bounds -> next_count, event). The top module holds all registers, priority logic and the capture option.

Test Plan (WIDTH = 8):
1. Reset with init_val = 8'h10, then enable up for 5 cycles -> count = 8'h15, tc = 0, ovf = 0.
2. Wrap mode, init_val = 3, limit_val = 6, counting up from 3 -> sequence 4, 5, 6, 3; tc is high only the cycle after 6 -> 3; ovf is set and stays set.
3. Saturate mode, down from init_val + 2 with init_val = 3 -> sequence 4, 3, 3, 3; tc is high each hold cycle; clr_ovf together with a hold event keeps ovf = 1; clr_ovf with enable = 0 clears it.
4. Load 8'hF0 with limit_val = 8'h20, init_val = 0, enable up -> count rolls F1 ... FF, 00 with no tc; tc first fires on 20 -> 00.
5. Reset together with load and enable mid-saturation -> count = init_val, tc = 0, ovf = 0 next cycle.
6. MODE_COUNTER_CAPTURE_EN build: capture at count = 8'h42 while counting up -> cap_val = 8'h42, count = 8'h43, cap_valid is a one-cycle pulse.

Source files
------------

// File: rtl/mode_counter_pkg.sv
// Shared direction/mode encodings for mode_counter and its next-state logic.
package mode_counter_pkg;

   // one-bit control field type used for both the dir and mode inputs
   typedef logic ctl_bit_t;

   localparam ctl_bit_t MODE_WRAP = 1'b0;
   localparam ctl_bit_t MODE_SAT  = 1'b1;
   localparam ctl_bit_t DIR_UP    = 1'b0;
   localparam ctl_bit_t DIR_DOWN  = 1'b1;

endpackage

// File: rtl/mode_counter_next.sv
// Combinational next-count and boundary-event calculation; zero latency, no flow control.
module mode_counter_next
   import mode_counter_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] count,
   input  ctl_bit_t         dir,
   input  ctl_bit_t         mode,
   input  logic [WIDTH-1:0] init_val,
   input  logic [WIDTH-1:0] limit_val,
   output logic [WIDTH-1:0] next_count,
   output logic             bound_evt
);

   localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

   // Bounds are equality checks only, so out-of-range counts roll modulo 2^WIDTH.
   always_comb begin
      next_count = count;
      bound_evt  = 1'b0;
      if (dir == DIR_UP) begin
         if (count == limit_val) begin
            bound_evt = 1'b1;
            if (mode == MODE_WRAP)
               next_count = init_val;
         end else begin
            next_count = count + ONE;
         end
      end else begin
         if (count == init_val) begin
            bound_evt = 1'b1;
            if (mode == MODE_WRAP)
               next_count = limit_val;
         end else begin
            next_count = count - ONE;
         end
      end
   end

endmodule

// File: rtl/mode_counter.sv
// Loadable up/down counter with wrap/saturate bounds, one-cycle tc pulse and sticky ovf;
// outputs registered one edge after inputs, no backpressure. Optional capture via MODE_COUNTER_CAPTURE_EN.
module mode_counter
   import mode_counter_pkg::*;
#(
   parameter int WIDTH    = 8,
   parameter bit RESET_TC = 1'b0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   input  logic             dir,
   input  logic             mode,
   input  logic [WIDTH-1:0] init_val,
   input  logic [WIDTH-1:0] limit_val,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             clr_ovf,
   output logic [WIDTH-1:0] count,
   output logic             tc,
   output logic             ovf
`ifdef MODE_COUNTER_CAPTURE_EN
   ,
   input  logic             capture,
   output logic [WIDTH-1:0] cap_val,
   output logic             cap_valid
`endif
);

   logic [WIDTH-1:0] next_count;
   logic             bound_evt;

   mode_counter_next #(.WIDTH(WIDTH)) u_next (
      .count      (count),
      .dir        (dir),
      .mode       (mode),
      .init_val   (init_val),
      .limit_val  (limit_val),
      .next_count (next_count),
      .bound_evt  (bound_evt)
   );

   // Priority reset > load > enable; a boundary event's ovf set overrides a same-cycle clr_ovf.
   always_ff @(posedge clk) begin
      if (reset) begin
         count <= init_val;
         tc    <= RESET_TC;
         ovf   <= RESET_TC;
      end else begin
         tc <= 1'b0;
         if (clr_ovf)
            ovf <= 1'b0;
         if (load) begin
            count <= load_val;
         end else if (enable) begin
            count <= next_count;
            if (bound_evt) begin
               tc  <= 1'b1;
               ovf <= 1'b1;
            end
         end
      end
   end

`ifdef MODE_COUNTER_CAPTURE_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         cap_val   <= '0;
         cap_valid <= 1'b0;
      end else begin
         cap_valid <= capture;
         if (capture)
            cap_val <= count;
      end
   end
`endif

endmodule

// File: tb/tb_mode_counter.sv
// Directed plan steps followed by randomized cycles, all checked against a behavioural model.
module tb_mode_counter;
   import mode_counter_pkg::*;

   logic       clk = 1'b0;
   logic       reset, enable, dir, mode, load, clr_ovf;
   logic [7:0] init_val, limit_val, load_val, count;
   logic       tc, ovf;
`ifdef MODE_COUNTER_CAPTURE_EN
   logic       capture;
   logic [7:0] cap_val;
   logic       cap_valid;
`endif

   int compared   = 0;
   int mismatched = 0;
   int mc, mtc, movf, mcap, mcapv;
   string phase = "init";

   always #5 clk = ~clk;

   mode_counter #(.WIDTH(8)) dut (
      .clk       (clk),
      .reset     (reset),
      .enable    (enable),
      .dir       (dir),
      .mode      (mode),
      .init_val  (init_val),
      .limit_val (limit_val),
      .load      (load),
      .load_val  (load_val),
      .clr_ovf   (clr_ovf),
      .count     (count),
      .tc        (tc),
      .ovf       (ovf)
`ifdef MODE_COUNTER_CAPTURE_EN
      ,
      .capture   (capture),
      .cap_val   (cap_val),
      .cap_valid (cap_valid)
`endif
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s/%s observed=%0h expected=%0h", phase, tag, obs, exp);
      end
   endtask

   // Apply one cycle of controls, advance the model by the spec rules, then compare.
   task automatic cyc(input logic r, input logic ld, input logic en, input logic d,
                      input logic m, input logic co, input logic cp);
      reset = r; load = ld; enable = en; dir = d; mode = m; clr_ovf = co;
`ifdef MODE_COUNTER_CAPTURE_EN
      capture = cp;
`endif
      if (r) begin
         mc = int'(init_val); mtc = 0; movf = 0; mcap = 0; mcapv = 0;
      end else begin
         mcapv = cp ? 1 : 0;
         if (cp) mcap = mc;
         mtc = 0;
         if (co) movf = 0;
         if (ld) begin
            mc = int'(load_val);
         end else if (en) begin
            if (!d) begin
               if (mc == int'(limit_val)) begin
                  mtc = 1; movf = 1;
                  if (!m) mc = int'(init_val);
               end else mc = (mc + 1) % 256;
            end else begin
               if (mc == int'(init_val)) begin
                  mtc = 1; movf = 1;
                  if (!m) mc = int'(limit_val);
               end else mc = (mc + 255) % 256;
            end
         end
      end
      @(posedge clk);
      #1;
      check("count", 32'(count), 32'(mc));
      check("tc", 32'(tc), 32'(mtc));
      check("ovf", 32'(ovf), 32'(movf));
`ifdef MODE_COUNTER_CAPTURE_EN
      check("cap_valid", 32'(cap_valid), 32'(mcapv));
      check("cap_val", 32'(cap_val), 32'(mcap));
`endif
   endtask

   initial begin
      int exp2 [4];
      int exp3 [4];
      reset = 1'b0; enable = 1'b0; dir = DIR_UP; mode = MODE_WRAP;
      load = 1'b0; clr_ovf = 1'b0; load_val = 8'h00;
      init_val = 8'h10; limit_val = 8'hFF;
`ifdef MODE_COUNTER_CAPTURE_EN
      capture = 1'b0;
`endif

      // 1: reset then five up counts
      phase = "p1";
      cyc(1, 0, 0, DIR_UP, MODE_WRAP, 0, 0);
      check("rst_tc", 32'(tc), 32'd0);
      check("rst_ovf", 32'(ovf), 32'd0);
      repeat (5) cyc(0, 0, 1, DIR_UP, MODE_WRAP, 0, 0);
      check("count15", 32'(count), 32'h15);

      // 2: wrap 3..6
      phase = "p2";
      init_val = 8'd3; limit_val = 8'd6;
      cyc(1, 0, 0, DIR_UP, MODE_WRAP, 0, 0);
      exp2 = '{4, 5, 6, 3};
      for (int i = 0; i < 4; i++) begin
         cyc(0, 0, 1, DIR_UP, MODE_WRAP, 0, 0);
         check("wrap_seq", 32'(count), 32'(exp2[i]));
         check("wrap_tc", 32'(tc), (i == 3) ? 32'd1 : 32'd0);
      end
      cyc(0, 0, 0, DIR_UP, MODE_WRAP, 0, 0);
      check("tc_pulse_end", 32'(tc), 32'd0);
      check("ovf_sticky", 32'(ovf), 32'd1);

      // 3: saturate down from init+2
      phase = "p3";
      load_val = 8'd5;
      cyc(0, 1, 0, DIR_DOWN, MODE_SAT, 0, 0);
      exp3 = '{4, 3, 3, 3};
      for (int i = 0; i < 4; i++) begin
         cyc(0, 0, 1, DIR_DOWN, MODE_SAT, 0, 0);
         check("sat_seq", 32'(count), 32'(exp3[i]));
         check("sat_tc", 32'(tc), (i >= 2) ? 32'd1 : 32'd0);
      end
      cyc(0, 0, 1, DIR_DOWN, MODE_SAT, 1, 0);
      check("clr_vs_set", 32'(ovf), 32'd1);
      cyc(0, 0, 0, DIR_DOWN, MODE_SAT, 1, 0);
      check("clr_idle", 32'(ovf), 32'd0);

      // 4: load outside bounds, roll through 0 to the limit
      phase = "p4";
      init_val = 8'h00; limit_val = 8'h20; load_val = 8'hF0;
      cyc(0, 1, 0, DIR_UP, MODE_WRAP, 0, 0);
      for (int i = 1; i <= 48; i++) begin
         cyc(0, 0, 1, DIR_UP, MODE_WRAP, 0, 0);
         check("roll_seq", 32'(count), 32'((8'hF0 + i) % 256));
         check("roll_no_tc", 32'(tc), 32'd0);
      end
      cyc(0, 0, 1, DIR_UP, MODE_WRAP, 0, 0);
      check("roll_tc_count", 32'(count), 32'h00);
      check("roll_tc", 32'(tc), 32'd1);

      // 5: reset beats load and enable during saturation hold
      phase = "p5";
      load_val = 8'h20;
      cyc(0, 1, 0, DIR_UP, MODE_SAT, 0, 0);
      cyc(0, 0, 1, DIR_UP, MODE_SAT, 0, 0);
      check("hold_tc", 32'(tc), 32'd1);
      init_val = 8'h07; load_val = 8'h55;
      cyc(1, 1, 1, DIR_UP, MODE_SAT, 0, 0);
      check("rst_mid_count", 32'(count), 32'h07);
      check("rst_mid_tc", 32'(tc), 32'd0);
      check("rst_mid_ovf", 32'(ovf), 32'd0);

`ifdef MODE_COUNTER_CAPTURE_EN
      // 6: capture the pre-update count
      phase = "p6";
      init_val = 8'h00; limit_val = 8'hFF; load_val = 8'h40;
      cyc(0, 1, 0, DIR_UP, MODE_WRAP, 0, 0);
      cyc(0, 0, 1, DIR_UP, MODE_WRAP, 0, 0);
      cyc(0, 0, 1, DIR_UP, MODE_WRAP, 0, 0);
      cyc(0, 0, 1, DIR_UP, MODE_WRAP, 0, 1);
      check("cap_42", 32'(cap_val), 32'h42);
      check("cap_cnt_43", 32'(count), 32'h43);
      check("cap_pulse", 32'(cap_valid), 32'd1);
      cyc(0, 0, 1, DIR_UP, MODE_WRAP, 0, 0);
      check("cap_pulse_end", 32'(cap_valid), 32'd0);
      cyc(1, 0, 0, DIR_UP, MODE_WRAP, 0, 1);
      check("cap_rst", 32'(cap_valid), 32'd0);
`endif

      // random: narrow windows so both bounds are reached often
      phase = "rand";
      for (int n = 0; n < 600; n++) begin
         if ($urandom_range(0, 15) == 0) begin
            init_val  = 8'($urandom);
            limit_val = init_val + 8'($urandom_range(0, 6));
         end
         if ($urandom_range(0, 63) == 0) limit_val = 8'($urandom);
         load_val = 8'($urandom);
         cyc(($urandom_range(0, 39) == 0), ($urandom_range(0, 9) == 0),
             ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), ($urandom_range(0, 5) == 0),
             ($urandom_range(0, 3) == 0));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
